// File: rtl/fifo_rd_serializer_if.sv
// Bundles the FIFO read port, the byte stream toward the consumer and the status
// outputs of fifo_rd_serializer into one interface.
interface fifo_rd_serializer_if #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 empty_i;
    logic                 rd_en_o;
    logic [WIDTH-1:0]     rdata_i;
    logic                 rd_error_i;
    logic [OUT_WIDTH-1:0] m_data_o;
    logic                 m_valid_o;
    logic                 m_ready_i;
    logic                 m_last_o;
    logic [CNT_WIDTH-1:0] word_cnt_o;
    logic                 err_o;
    logic                 busy_o;

    modport master (
        input  empty_i, rdata_i, rd_error_i, m_ready_i,
        output rd_en_o, m_data_o, m_valid_o, m_last_o, word_cnt_o, err_o, busy_o
    );

    modport slave (
        output empty_i, rdata_i, rd_error_i, m_ready_i,
        input  rd_en_o, m_data_o, m_valid_o, m_last_o, word_cnt_o, err_o, busy_o
    );
endinterface

// File: rtl/fifo_rd_serializer.sv
// Read side of the dual-clock FIFO: pops one word at a time and streams it out as
// OUT_WIDTH-bit beats, counting completed words and latching FIFO read errors.
module fifo_rd_serializer #(
    parameter int WIDTH      = 16,
    parameter int OUT_WIDTH  = 8,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fifo_rd_serializer_if.master bus
);
    localparam int N      = WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     shift_r;
    logic [BEAT_W-1:0]    beat_r;
    logic [BEAT_W-1:0]    beat_nxt_s;
    logic                 rd_en_r;
    logic [OUT_WIDTH-1:0] m_data_r;
    logic                 m_valid_r;
    logic                 m_last_r;
    logic [CNT_WIDTH-1:0] word_cnt_r;
    logic                 err_r;
    logic                 busy_r;

    // Selects beat k of a word, honouring the configured chunk order.
    function automatic logic [OUT_WIDTH-1:0] chunk_of(input logic [WIDTH-1:0] word,
                                                      input logic [BEAT_W-1:0] k);
        logic [WIDTH-1:0] shifted_s;
        int               idx_s;
        idx_s     = BIG_ENDIAN ? (N - 1 - int'(k)) : int'(k);
        shifted_s = word >> (idx_s * OUT_WIDTH);
        return shifted_s[OUT_WIDTH-1:0];
    endfunction

    assign beat_nxt_s = beat_r + BEAT_W'(1);

    // Main fetch/load/send sequencer with all stream and FIFO outputs registered.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= IDLE;
            shift_r    <= {WIDTH{1'b0}};
            beat_r     <= {BEAT_W{1'b0}};
            rd_en_r    <= 1'b0;
            m_data_r   <= {OUT_WIDTH{1'b0}};
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
            word_cnt_r <= {CNT_WIDTH{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!bus.empty_i) begin
                        state_r <= FETCH;
                        rd_en_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    state_r <= LOAD;
                    rd_en_r <= 1'b0;
                end
                LOAD: begin
                    shift_r   <= bus.rdata_i;
                    beat_r    <= {BEAT_W{1'b0}};
                    m_data_r  <= chunk_of(bus.rdata_i, {BEAT_W{1'b0}});
                    m_valid_r <= 1'b1;
                    m_last_r  <= (N == 1) ? 1'b1 : 1'b0;
                    state_r   <= SEND;
                end
                SEND: begin
                    if (m_valid_r && bus.m_ready_i) begin
                        if (beat_r == LAST_BEAT) begin
                            m_valid_r  <= 1'b0;
                            m_last_r   <= 1'b0;
                            word_cnt_r <= word_cnt_r + CNT_WIDTH'(1);
                            // Chain straight into the next pop when more data is waiting.
                            if (!bus.empty_i) begin
                                state_r <= FETCH;
                                rd_en_r <= 1'b1;
                            end else begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            beat_r   <= beat_nxt_s;
                            m_data_r <= chunk_of(shift_r, beat_nxt_s);
                            m_last_r <= (beat_nxt_s == LAST_BEAT) ? 1'b1 : 1'b0;
                        end
                    end else begin
                        state_r <= SEND;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    rd_en_r   <= 1'b0;
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky read-error flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_r <= 1'b0;
        end else if (bus.rd_error_i) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.rd_en_o    = rd_en_r;
    assign bus.m_data_o   = m_data_r;
    assign bus.m_valid_o  = m_valid_r;
    assign bus.m_last_o   = m_last_r;
    assign bus.word_cnt_o = word_cnt_r;
    assign bus.err_o      = err_r;
    assign bus.busy_o     = busy_r;
endmodule
